// File: rtl/stats_arbiter_if.sv
// Requester, register-read and clear-all signals of the shared statistics engine.
// The master modport drives requests and commands; the slave modport is the engine.
interface stats_arbiter_if #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned IDX_WIDTH   = 2,
  parameter int unsigned INC_WIDTH   = 8,
  parameter int unsigned STATS_WIDTH = 32
);
  logic [NUM_REQ-1:0]           reqValid;
  logic [NUM_REQ*INC_WIDTH-1:0] reqInc;
  logic [NUM_REQ-1:0]           reqReady;
  logic                         rdValid;
  logic [IDX_WIDTH-1:0]         rdIdx;
  logic                         rdClear;
  logic                         rdDone;
  logic [STATS_WIDTH-1:0]       rdData;
  logic                         clearAll;
  logic                         busy;

  modport master (
    output reqValid, reqInc, rdValid, rdIdx, rdClear, clearAll,
    input  reqReady, rdDone, rdData, busy
  );

  modport slave (
    input  reqValid, reqInc, rdValid, rdIdx, rdClear, clearAll,
    output reqReady, rdDone, rdData, busy
  );
endinterface

// File: rtl/stats_arbiter.sv
// Round-robin arbitrated counter bank with a registered read port (optional clear-on-read)
// and a sequential clear-all that walks every counter once.
module stats_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned IDX_WIDTH   = 2,
  parameter int unsigned INC_WIDTH   = 8,
  parameter int unsigned STATS_WIDTH = 32
) (
  input logic             clock,
  input logic             reset,
  stats_arbiter_if.slave  bus
);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e                 state_q, state_d;
  logic [IDX_WIDTH-1:0]   clr_idx_q, clr_idx_d;
  logic [IDX_WIDTH-1:0]   ptr_q, ptr_d;
  logic [STATS_WIDTH-1:0] cnt_q [NUM_REQ];
  logic [STATS_WIDTH-1:0] cnt_d [NUM_REQ];
  logic                   rd_done_q, rd_done_d;
  logic [STATS_WIDTH-1:0] rd_data_q, rd_data_d;

  logic [NUM_REQ-1:0]     grant;
  logic [IDX_WIDTH-1:0]   grant_idx;
  logic [IDX_WIDTH-1:0]   cand;
  logic                   grant_any;

  // Search upward from ptr; the index width wraps naturally since NUM_REQ is a power of two.
  always_comb begin
    grant     = '0;
    grant_idx = ptr_q;
    grant_any = 1'b0;
    cand      = '0;
    if (state_q == StIdle && !reset) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        cand = ptr_q + IDX_WIDTH'(k);
        if (!grant_any && bus.reqValid[cand]) begin
          grant_any = 1'b1;
          grant_idx = cand;
        end
      end
    end
    if (grant_any) grant[grant_idx] = 1'b1;
  end

  assign ptr_d = grant_any ? grant_idx + IDX_WIDTH'(1) : ptr_q;

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    unique case (state_q)
      StIdle: begin
        if (bus.clearAll) begin
          state_d   = StClear;
          clr_idx_d = '0;
        end
      end
      StClear: begin
        clr_idx_d = clr_idx_q + IDX_WIDTH'(1);
        if (clr_idx_q == IDX_WIDTH'(NUM_REQ - 1)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Clear-on-read zeroes first so a same-cycle increment survives; clear-all wins over both.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (bus.rdValid && bus.rdClear && bus.rdIdx == IDX_WIDTH'(i)) cnt_d[i] = '0;
      if (grant[i]) begin
        cnt_d[i] = cnt_d[i] + STATS_WIDTH'(bus.reqInc[i*INC_WIDTH +: INC_WIDTH]);
      end
      if (state_q == StClear && clr_idx_q == IDX_WIDTH'(i)) cnt_d[i] = '0;
    end
  end

  assign rd_done_d = bus.rdValid;
  assign rd_data_d = bus.rdValid ? cnt_q[bus.rdIdx] : rd_data_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      clr_idx_q <= '0;
      ptr_q     <= '0;
      rd_done_q <= 1'b0;
      rd_data_q <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      ptr_q     <= ptr_d;
      rd_done_q <= rd_done_d;
      rd_data_q <= rd_data_d;
      for (int unsigned i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign bus.reqReady = grant;
  assign bus.rdDone   = rd_done_q;
  assign bus.rdData   = rd_data_q;
  assign bus.busy     = (state_q == StClear);

endmodule

// File: tb/tb_stats_arbiter.sv
// Self-checking bench for stats_arbiter: directed vector table, hand-written corner sequences
// and random traffic compared against a cycle-level reference model of the counter bank.
module tb_stats_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  stats_arbiter_if #(.NUM_REQ(4), .IDX_WIDTH(2), .INC_WIDTH(8), .STATS_WIDTH(32)) bus ();
  stats_arbiter_if #(.NUM_REQ(4), .IDX_WIDTH(2), .INC_WIDTH(8), .STATS_WIDTH(8))  bus8 ();

  stats_arbiter #(.NUM_REQ(4), .IDX_WIDTH(2), .INC_WIDTH(8), .STATS_WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  stats_arbiter #(.NUM_REQ(4), .IDX_WIDTH(2), .INC_WIDTH(8), .STATS_WIDTH(8)) dut8 (
    .clock (clock),
    .reset (reset),
    .bus   (bus8.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: counters as plain numbers, clear-all as a count of remaining cycles.
  longint unsigned m_cnt [4];
  longint unsigned m_data;
  int              m_ptr, m_left, m_cidx;
  bit              m_done;
  localparam longint unsigned Mask32 = 64'hFFFF_FFFF;

  task automatic m_reset();
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    m_data = 0; m_ptr = 0; m_left = 0; m_cidx = 0; m_done = 0;
  endtask

  function automatic int m_grant(input logic [3:0] v);
    if (m_left > 0) return -1;
    for (int k = 0; k < 4; k++) if (v[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    return -1;
  endfunction

  task automatic m_step(input logic [31:0] inc, input logic rv, input logic [1:0] ri,
                        input logic rc, input logic ca, input int g);
    if (rv) begin m_data = m_cnt[ri]; m_done = 1; end
    else m_done = 0;
    if (rv && rc) m_cnt[ri] = 0;
    if (g >= 0) begin
      m_cnt[g] = (m_cnt[g] + longint'(inc[g*8 +: 8])) & Mask32;
      m_ptr = (g + 1) % 4;
    end
    if (m_left > 0) begin
      m_cnt[m_cidx] = 0; m_cidx++; m_left--;
    end else if (ca) begin
      m_left = 4; m_cidx = 0;
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [31:0] inc, input logic rv,
                       input logic [1:0] ri, input logic rc, input logic ca);
    bus.reqValid = v; bus.reqInc = inc; bus.rdValid = rv;
    bus.rdIdx = ri; bus.rdClear = rc; bus.clearAll = ca;
  endtask

  // One clock: check registered outputs, apply inputs, check grant, advance the model.
  task automatic cycle(input logic [3:0] v, input logic [31:0] inc, input logic rv,
                       input logic [1:0] ri, input logic rc, input logic ca,
                       output logic [3:0] o_ready, output logic o_done,
                       output logic [31:0] o_data, output logic o_busy);
    int g;
    @(negedge clock);
    o_done = bus.rdDone; o_data = bus.rdData; o_busy = bus.busy;
    chk("rdDone", 64'(o_done), 64'(m_done));
    chk("rdData", 64'(o_data), m_data);
    chk("busy", 64'(o_busy), 64'(m_left > 0));
    drive(v, inc, rv, ri, rc, ca);
    #1;
    o_ready = bus.reqReady;
    g = m_grant(v);
    chk("reqReady", 64'(o_ready), (g < 0) ? 64'd0 : (64'd1 << g));
    @(posedge clock);
    m_step(inc, rv, ri, rc, ca, g);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    drive(4'h0, 32'h0, 1'b0, 2'd0, 1'b0, 1'b0);
    m_reset();
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  typedef struct {
    bit          rst;
    logic [3:0]  v;
    logic [31:0] inc;
    logic        rv;
    logic [1:0]  ri;
    logic [3:0]  exp_ready;
    logic        exp_done;
    logic [31:0] exp_data;
  } vec_t;

  vec_t tbl [18];

  logic [3:0]  r;
  logic        d, b;
  logic [31:0] dat;
  int          saved_ptr, busy_cycles;

  initial begin
    // Single requester at index 2, then read it back.
    tbl[0]  = '{1, 4'h4, 32'h0005_0000, 0, 2'd0, 4'h4, 0, 32'd0};
    tbl[1]  = '{0, 4'h4, 32'h0005_0000, 0, 2'd0, 4'h4, 0, 32'd0};
    tbl[2]  = '{0, 4'h4, 32'h0005_0000, 0, 2'd0, 4'h4, 0, 32'd0};
    tbl[3]  = '{0, 4'h0, 32'h0,         1, 2'd2, 4'h0, 0, 32'd0};
    tbl[4]  = '{0, 4'h0, 32'h0,         0, 2'd0, 4'h0, 1, 32'd15};
    // Fairness from reset: all requesters, increment 1 each.
    tbl[5]  = '{1, 4'hF, 32'h0101_0101, 0, 2'd0, 4'h1, 0, 32'd0};
    tbl[6]  = '{0, 4'hF, 32'h0101_0101, 0, 2'd0, 4'h2, 0, 32'd0};
    tbl[7]  = '{0, 4'hF, 32'h0101_0101, 0, 2'd0, 4'h4, 0, 32'd0};
    tbl[8]  = '{0, 4'hF, 32'h0101_0101, 0, 2'd0, 4'h8, 0, 32'd0};
    tbl[9]  = '{0, 4'hF, 32'h0101_0101, 0, 2'd0, 4'h1, 0, 32'd0};
    tbl[10] = '{0, 4'hF, 32'h0101_0101, 0, 2'd0, 4'h2, 0, 32'd0};
    tbl[11] = '{0, 4'hF, 32'h0101_0101, 0, 2'd0, 4'h4, 0, 32'd0};
    tbl[12] = '{0, 4'hF, 32'h0101_0101, 0, 2'd0, 4'h8, 0, 32'd0};
    tbl[13] = '{0, 4'h0, 32'h0,         1, 2'd0, 4'h0, 0, 32'd0};
    tbl[14] = '{0, 4'h0, 32'h0,         1, 2'd1, 4'h0, 1, 32'd2};
    tbl[15] = '{0, 4'h0, 32'h0,         1, 2'd2, 4'h0, 1, 32'd2};
    tbl[16] = '{0, 4'h0, 32'h0,         1, 2'd3, 4'h0, 1, 32'd2};
    tbl[17] = '{0, 4'h0, 32'h0,         0, 2'd0, 4'h0, 1, 32'd2};

    bus8.reqValid = '0; bus8.reqInc = '0; bus8.rdValid = 1'b0;
    bus8.rdIdx = '0; bus8.rdClear = 1'b0; bus8.clearAll = 1'b0;
    m_reset();

    // Reset state, with requests present while reset is held.
    drive(4'hF, 32'h0101_0101, 1'b0, 2'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    chk("reset_reqReady", 64'(bus.reqReady), 64'd0);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_rdDone", 64'(bus.rdDone), 64'd0);
    chk("reset_rdData", 64'(bus.rdData), 64'd0);

    for (int i = 0; i < 18; i++) begin
      if (tbl[i].rst) do_reset();
      cycle(tbl[i].v, tbl[i].inc, tbl[i].rv, tbl[i].ri, 1'b0, 1'b0, r, d, dat, b);
      chk($sformatf("tbl%0d_ready", i), 64'(r), 64'(tbl[i].exp_ready));
      chk($sformatf("tbl%0d_done", i), 64'(d), 64'(tbl[i].exp_done));
      chk($sformatf("tbl%0d_data", i), 64'(dat), 64'(tbl[i].exp_data));
    end

    // Read-clear colliding with a grant to the same counter.
    cycle(4'h2, 32'h0, 1'b1, 2'd1, 1'b1, 1'b0, r, d, dat, b);
    cycle(4'h2, 32'h0000_0700, 1'b0, 2'd0, 1'b0, 1'b0, r, d, dat, b);
    cycle(4'h2, 32'h0000_0300, 1'b1, 2'd1, 1'b1, 1'b0, r, d, dat, b);
    chk("rdclr_grant", 64'(r), 64'h2);
    cycle(4'h0, 32'h0, 1'b1, 2'd1, 1'b0, 1'b0, r, d, dat, b);
    chk("rdclr_old", 64'(dat), 64'd7);
    cycle(4'h0, 32'h0, 1'b0, 2'd0, 1'b0, 1'b0, r, d, dat, b);
    chk("rdclr_new", 64'(dat), 64'd3);

    // Clear-all with requests held; a second pulse mid-sequence is ignored.
    repeat (4) cycle(4'hF, 32'h0102_0304, 1'b0, 2'd0, 1'b0, 1'b0, r, d, dat, b);
    cycle(4'hF, 32'h0102_0304, 1'b0, 2'd0, 1'b0, 1'b1, r, d, dat, b);
    saved_ptr   = m_ptr;
    busy_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(4'hF, 32'h0102_0304, 1'b0, 2'd0, 1'b0, (i == 1), r, d, dat, b);
      if (b) busy_cycles++;
      chk("clr_ready_zero", 64'(r), 64'd0);
    end
    cycle(4'h0, 32'h0, 1'b1, 2'd0, 1'b0, 1'b0, r, d, dat, b);
    chk("clr_busy_cycles", 64'(busy_cycles), 64'd4);
    chk("clr_busy_low", 64'(b), 64'd0);
    for (int i = 1; i < 5; i++) begin
      cycle(4'h0, 32'h0, (i < 4), 2'(i), 1'b0, 1'b0, r, d, dat, b);
      chk($sformatf("clr_read%0d", i - 1), 64'(dat), 64'd0);
    end
    cycle(4'hF, 32'h0101_0101, 1'b0, 2'd0, 1'b0, 1'b0, r, d, dat, b);
    chk("clr_resume", 64'(r), 64'd1 << saved_ptr);

    // Reset asserted while clrIdx=1, with a read response pending.
    cycle(4'h0, 32'h0, 1'b0, 2'd0, 1'b0, 1'b1, r, d, dat, b);
    cycle(4'h3, 32'h0909_0909, 1'b1, 2'd3, 1'b0, 1'b0, r, d, dat, b);
    @(negedge clock);
    chk("midclr_busy_before", 64'(bus.busy), 64'd1);
    chk("midclr_done_before", 64'(bus.rdDone), 64'd1);
    reset = 1'b1;
    drive(4'h0, 32'h0, 1'b0, 2'd0, 1'b0, 1'b0);
    #1;
    chk("midclr_busy", 64'(bus.busy), 64'd0);
    chk("midclr_done", 64'(bus.rdDone), 64'd0);
    m_reset();
    @(posedge clock);
    #1 reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle(4'h0, 32'h0, (i < 4), 2'(i), 1'b0, 1'b0, r, d, dat, b);
      if (i > 0) chk($sformatf("midclr_read%0d", i - 1), 64'(dat), 64'd0);
    end
    cycle(4'hF, 32'h0101_0101, 1'b0, 2'd0, 1'b0, 1'b0, r, d, dat, b);
    chk("midclr_first_grant", 64'(r), 64'h1);

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      cycle(4'($urandom), $urandom, 1'($urandom), 2'($urandom), ($urandom_range(3) == 0),
            ($urandom_range(39) == 0), r, d, dat, b);
    end

    // Wrap on the 8-bit instance: 26 increments of 10 = 260 -> 4.
    do_reset();
    for (int i = 0; i < 26; i++) begin
      @(negedge clock);
      bus8.reqValid = 4'h1;
      bus8.reqInc   = 32'h0000_000A;
      #1;
      if (i == 0 || i == 25) chk("wrap_ready", 64'(bus8.reqReady), 64'h1);
    end
    @(negedge clock);
    bus8.reqValid = 4'h0;
    bus8.rdValid  = 1'b1;
    bus8.rdIdx    = 2'd0;
    @(negedge clock);
    bus8.rdValid  = 1'b0;
    chk("wrap_done", 64'(bus8.rdDone), 64'd1);
    chk("wrap_data", 64'(bus8.rdData), 64'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stats_arbiter.md
# stats_arbiter

Shared statistics engine for the DMA datapath. NUM_REQ requesters present increment events; a round-robin arbiter grants one per cycle and applies its increment to that requester's counter in a single shared counter bank. A register-side port reads counters, optionally with clear-on-read. A sequencer clears all counters on request.

## Interface
- NUM_REQ, 4, number of requesters and counters (power of two, at least 2)
- IDX_WIDTH, 2, log2(NUM_REQ)
- INC_WIDTH, 8, width of each increment value
- STATS_WIDTH, 32, counter width (at least INC_WIDTH)

- clock  input  1  single clock domain; all state changes on its rising edge
- reset  input  1  asynchronous, active-high reset
- reqValid  input  NUM_REQ  per-requester increment request
- reqInc  input  NUM_REQ*INC_WIDTH  increment values; requester i uses bits [i*INC_WIDTH +: INC_WIDTH]
- reqReady  output  NUM_REQ  one-hot grant, combinational; transfer when reqValid[i] & reqReady[i]
- rdValid  input  1  single-cycle read command
- rdIdx  input  IDX_WIDTH  counter index to read
- rdClear  input  1  clear the counter as part of the read; sampled with rdValid
- rdDone  output  1  one-cycle pulse; rdData is valid
- rdData  output  STATS_WIDTH  registered read data
- clearAll  input  1  pulse; starts the clear-all sequence
- busy  output  1  high while the clear-all sequence runs

## Operation
- States: IDLE and CLEAR. Reset enters IDLE.
- IDLE with clearAll=1: go to CLEAR and set clrIdx=0.
- CLEAR: each cycle, write 0 to counter[clrIdx] and increment clrIdx. After the cycle with clrIdx=NUM_REQ-1, return to IDLE. The sequence takes exactly NUM_REQ cycles.
- clearAll received while in CLEAR is ignored.
- busy is high exactly while the state is CLEAR.
- Arbitration runs only in IDLE. In CLEAR, reqReady=0.
- Round-robin pointer ptr:
  - The grant goes to the first i with reqValid[i]=1, searching from ptr upward modulo NUM_REQ.
  - After a grant to i, ptr becomes (i+1) mod NUM_REQ.
  - With no grant, ptr holds.
- Update on a granted transfer: counter[i] becomes counter[i] + zero-extend(reqInc[i]), modulo 2^STATS_WIDTH (wraps, no saturation). An increment of 0 still consumes the grant.
- Read command: rdValid samples counter[rdIdx] before any same-cycle update. That pre-update value appears on rdData in the next cycle, with rdDone=1.
- Read with clear, plus a same-cycle grant to the same index: the counter becomes the increment value only. No event is lost.
- Read with clear, plus a same-cycle clear-all write to the same index: the counter becomes 0.
- rdValid is accepted every cycle, including during CLEAR. It never stalls arbitration.
- A read with an out-of-range index cannot occur, because NUM_REQ is a power of two.

## Timing
- Reset values:
  - all counters 0, ptr=0, state IDLE, clrIdx=0
  - rdDone=0, rdData=0, busy=0
  - reqReady=0 while reset is asserted
- Grant latency: reqReady is asserted in the same cycle as reqValid, combinationally from reqValid, ptr and state. At most one bit of reqReady is set.
- Update latency: a counter changes at the rising edge that ends the transfer cycle. A read issued in the next cycle sees the new value.
- Read latency: one cycle from rdValid to rdDone/rdData. rdData holds its value until the next read. Back-to-back reads give back-to-back rdDone pulses.
- busy rises in the cycle after clearAll is sampled and stays high for NUM_REQ cycles.
- Reset mid-operation: an asserted reset immediately clears all state, including an in-progress CLEAR sequence and a pending rdDone.

## Test plan
- Single requester: reqValid[2]=1 with reqInc=5 for 3 cycles, then read idx 2 → reqReady[2]=1 each cycle; rdData=15 with rdDone one cycle after rdValid.
- Fairness: all four reqValid held high, each with reqInc=1, for 8 cycles from reset → grant order 0,1,2,3,0,1,2,3; each counter reads 2.
- Wrap: STATS_WIDTH=8, preload counter 0 to 250, increment by 10 → read returns 4.
- Read-clear collision: counter 1 = 7; in one cycle rdValid, rdIdx=1, rdClear=1 and a grant to requester 1 with reqInc=3 → rdData=7; a subsequent read returns 3.
- Clear-all: all counters nonzero, clearAll pulse with requests held → busy high 4 cycles with reqReady=0; all counters read 0 afterwards; grants resume at the saved ptr.
- Reset mid-CLEAR: assert reset during clrIdx=1 → busy=0 and rdDone=0 immediately; after release, all counters read 0 and the first grant goes to requester 0.
